// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus the key-code bus from the scanner to the decoders
// master: scanner side (reads row_n, drives col_n/key_code/key_valid/key_held)
// slave:  keypad/decoder side
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    modport master (input row_n, output col_n, key_code, key_valid, key_held);
    modport slave (output row_n, input col_n, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces presses/releases and emits 4-bit key codes
// Ports: clk, rst (async, active-high); kp (keypad_scanner_if.master):
//   row_n in (async rows), col_n out (one-hot-zero drive), key_code out,
//   key_valid out (1-cycle strobe), key_held out (press accepted, release not yet accepted)
// Optional: define KEYPAD_REPEAT_EN to enable auto-repeat strobes while a key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 1000,
    parameter int REPEAT_DLY   = 50000,
    parameter int REPEAT_PER   = 10000
) (
    input logic clk,
    input logic rst,
    keypad_scanner_if.master kp
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CNT - 1);
    // nibble index {row, col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
    localparam logic [63:0] KEY_MAP = 64'hDE0F_C987_B654_A321;
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_PER < 1 || REPEAT_PER > REPEAT_DLY)
        $error("keypad_scanner: illegal parameter combination");
    state_t state, state_nx;
    logic [3:0] rs_m, rs, code, code_nx;
    logic [SW-1:0] div, div_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0] col, col_nx, row, row_nx, row_enc;
    logic valid, valid_nx, held, held_nx, row_only, rpt_fire;
    // row index of the single low row (only meaningful when exactly one is low)
    assign row_enc = {~rs[3] | ~rs[2], ~rs[3] | ~rs[1]};
    assign row_only = rs == ~(4'b0001 << row);
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DLY);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DLY - REPEAT_PER);
    logic [RW-1:0] rpt, rpt_nx;
    // cleared while debouncing so every accepted press starts a fresh delay;
    // frozen in RELEASE so a bounce back to HELD keeps its progress
    always_comb begin
        rpt_nx = rpt;
        rpt_fire = 1'b0;
        if (state == DEBOUNCE)
            rpt_nx = '0;
        else if (state == HELD && !rs[row]) begin
            rpt_fire = rpt == RPT_LAST;
            rpt_nx = rpt_fire ? RPT_RELOAD : rpt + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) rpt <= '0;
        else rpt <= rpt_nx;
`else
    assign rpt_fire = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        div_nx = div;
        cnt_nx = cnt;
        col_nx = col;
        row_nx = row;
        code_nx = code;
        held_nx = held;
        valid_nx = rpt_fire;
        case (state)
            SCAN: begin
                div_nx = div == SCAN_LAST ? '0 : div + 1'b1;
                if (div == SCAN_LAST && $onehot(~rs)) begin
                    row_nx = row_enc;
                    cnt_nx = '0;
                    state_nx = DEBOUNCE;
                end else if (div == SCAN_LAST)
                    col_nx = col + 1'b1;
            end
            DEBOUNCE: begin
                if (!row_only) begin
                    state_nx = SCAN;
                    cnt_nx = '0;
                    div_nx = '0;
                    col_nx = col + 1'b1;
                end else if (cnt == DB_LAST) begin
                    state_nx = HELD;
                    cnt_nx = '0;
                    valid_nx = 1'b1;
                    held_nx = 1'b1;
                    code_nx = KEY_MAP[{row, col, 2'b00} +: 4];
                end else
                    cnt_nx = cnt + 1'b1;
            end
            HELD: begin
                if (rs[row]) begin
                    state_nx = RELEASE;
                    cnt_nx = '0;
                end
            end
            RELEASE: begin
                if (!rs[row]) begin
                    state_nx = HELD;
                    cnt_nx = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = SCAN;
                    cnt_nx = '0;
                    div_nx = '0;
                    held_nx = 1'b0;
                    col_nx = col + 1'b1;
                end else
                    cnt_nx = cnt + 1'b1;
            end
            default: state_nx = SCAN;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= SCAN;
            rs_m <= 4'hF;
            rs <= 4'hF;
            div <= '0;
            cnt <= '0;
            col <= '0;
            row <= '0;
            code <= '0;
            valid <= 1'b0;
            held <= 1'b0;
        end else begin
            state <= state_nx;
            rs_m <= kp.row_n;
            rs <= rs_m;
            div <= div_nx;
            cnt <= cnt_nx;
            col <= col_nx;
            row <= row_nx;
            code <= code_nx;
            valid <= valid_nx;
            held <= held_nx;
        end
    assign kp.col_n = ~(4'b0001 << col);
    assign kp.key_code = code;
    assign kp.key_valid = valid;
    assign kp.key_held = held;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized self-checking bench for keypad_scanner with a switch-matrix keypad model
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] pressed = '0;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit held_seen = 1'b0;
    logic [3:0] prev_code = 4'h0;
    logic [3:0] s_code[$];
    int s_cyc[$];
    logic [3:0] kmap[16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'hE, 4'hD};

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_DLY(40), .REPEAT_PER(16)) dut (
        .clk(clk),
        .rst(rst),
        .kp(kp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a pressed switch at (r, c) shorts row r to column c; rows are pulled up
    always_comb begin
        kp.row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            kp.row_n[r] = ~|(pressed[r*4 +: 4] & ~kp.col_n);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (kp.key_valid) begin
                s_code.push_back(kp.key_code);
                s_cyc.push_back(cyc);
            end
            if (kp.key_held) held_seen = 1'b1;
            vectors++;
            if (kp.key_code !== prev_code && !kp.key_valid) begin
                miscompares++;
                $display("FAIL code_stable: key_code %h changed from %h without key_valid", kp.key_code, prev_code);
            end
        end
        prev_code = kp.key_code;
    end

    function automatic int idx(int r, int c);
        return r * 4 + c;
    endfunction

    task automatic clear_log();
        s_code.delete();
        s_cyc.delete();
        held_seen = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        repeat (3) @(negedge clk);
        vectors++;
        if (kp.col_n !== 4'b1110 || kp.key_code !== 4'h0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: col_n=%b code=%h valid=%b held=%b, want 1110/0/0/0",
                     kp.col_n, kp.key_code, kp.key_valid, kp.key_held);
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            vectors++;
            if (kp.col_n !== exp_col) begin
                miscompares++;
                $display("FAIL scan_rotate: cycle %0d col_n=%b want %b", k, kp.col_n, exp_col);
            end
        end
    endtask

    task automatic test_key5();
        int t0;
        clear_log();
        t0 = cyc;
        pressed[idx(1, 1)] = 1'b1;
        repeat (100) @(negedge clk);
        vectors++;
        if (kp.key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL held_during_press: key_held=%b want 1", kp.key_held);
        end
        pressed = '0;
        repeat (9) @(negedge clk);
        vectors++;
        if (kp.key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL held_release_debounce: key_held=%b want 1", kp.key_held);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (kp.key_held !== 1'b0 || kp.col_n !== 4'b1011) begin
            miscompares++;
            $display("FAIL release_resume: key_held=%b col_n=%b want 0/1011", kp.key_held, kp.col_n);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (s_code.size() != 1) begin
            miscompares++;
            $display("FAIL key5_count: %0d strobes want 1", s_code.size());
        end else begin
            vectors++;
            if (s_code[0] !== 4'h5 || s_cyc[0] - t0 > 26 || s_cyc[0] - t0 < 8) begin
                miscompares++;
                $display("FAIL key5_code: code=%h latency=%0d want 5 within 8..26", s_code[0], s_cyc[0] - t0);
            end
        end
    endtask

    task automatic test_codes();
        int keys[4] = '{idx(3, 2), idx(3, 0), idx(3, 3), idx(3, 1)};
        int k, n;
        for (int i = 0; i < 10; i++) begin
            k = i < 4 ? keys[i] : int'($urandom_range(15));
            n = int'($urandom_range(40, 80));
            clear_log();
            pressed[k] = 1'b1;
            repeat (n) @(negedge clk);
            pressed = '0;
            repeat (20) @(negedge clk);
            vectors++;
            if (s_code.size() != 1) begin
                miscompares++;
                $display("FAIL code_count: key %0d gave %0d strobes want 1", k, s_code.size());
            end else begin
                vectors++;
                if (s_code[0] !== kmap[k]) begin
                    miscompares++;
                    $display("FAIL code_value: key %0d code=%h want %h", k, s_code[0], kmap[k]);
                end
            end
        end
    endtask

    task automatic test_bounce();
        clear_log();
        for (int i = 0; i < 5; i++) begin
            pressed[idx(2, 0)] = 1'b1;
            repeat (3) @(negedge clk);
            pressed = '0;
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (s_code.size() != 0 || held_seen) begin
            miscompares++;
            $display("FAIL press_bounce: %0d strobes held_seen=%b want 0/0", s_code.size(), held_seen);
        end
        clear_log();
        pressed[idx(2, 0)] = 1'b1;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            pressed = '0;
            repeat (3) @(negedge clk);
            pressed[idx(2, 0)] = 1'b1;
            repeat (3) @(negedge clk);
        end
        pressed = '0;
        repeat (20) @(negedge clk);
        vectors++;
        if (s_code.size() != 1 || (s_code.size() == 1 && s_code[0] !== 4'h7)) begin
            miscompares++;
            $display("FAIL release_bounce: %0d strobes, want exactly one 7", s_code.size());
        end
    endtask

    task automatic test_multi();
        clear_log();
        pressed[idx(0, 0)] = 1'b1;
        pressed[idx(1, 0)] = 1'b1;
        repeat (60) @(negedge clk);
        pressed = '0;
        repeat (20) @(negedge clk);
        vectors++;
        if (s_code.size() != 0) begin
            miscompares++;
            $display("FAIL two_rows: %0d strobes want 0", s_code.size());
        end
        clear_log();
        pressed[idx(0, 0)] = 1'b1;
        repeat (50) @(negedge clk);
        pressed[idx(0, 1)] = 1'b1;
        repeat (50) @(negedge clk);
        pressed = '0;
        repeat (20) @(negedge clk);
        vectors++;
        if (s_code.size() != 1 || (s_code.size() == 1 && s_code[0] !== 4'h1)) begin
            miscompares++;
            $display("FAIL second_key: %0d strobes, want exactly one 1", s_code.size());
        end
    endtask

    task automatic test_reset_held();
        pressed[idx(2, 3)] = 1'b1;
        repeat (60) @(negedge clk);
        clear_log();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (kp.col_n !== 4'b1110 || kp.key_code !== 4'h0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: col_n=%b code=%h valid=%b held=%b want 1110/0/0/0",
                     kp.col_n, kp.key_code, kp.key_valid, kp.key_held);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        vectors++;
        if (s_code.size() != 1 || (s_code.size() == 1 && s_code[0] !== 4'hC)) begin
            miscompares++;
            $display("FAIL reaccept: %0d strobes, want exactly one C", s_code.size());
        end
        pressed = '0;
        repeat (20) @(negedge clk);
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int exp_off[$];
        int w = 0;
        clear_log();
        pressed[idx(2, 2)] = 1'b1;
        while (kp.key_held !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (kp.key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL repeat_accept: key_held=%b want 1 within 60 cycles", kp.key_held);
        end
        repeat (100) @(negedge clk);
        pressed = '0;
        repeat (20) @(negedge clk);
        exp_off.push_back(0);
        for (int o = 40; o < 100; o += 16) exp_off.push_back(o);
        vectors++;
        if (s_cyc.size() != exp_off.size()) begin
            miscompares++;
            $display("FAIL repeat_count: %0d strobes want %0d", s_cyc.size(), exp_off.size());
        end else
            for (int i = 0; i < exp_off.size(); i++) begin
                vectors++;
                if (s_cyc[i] - s_cyc[0] != exp_off[i] || s_code[i] !== 4'h9) begin
                    miscompares++;
                    $display("FAIL repeat_strobe: #%0d offset=%0d code=%h want %0d/9",
                             i, s_cyc[i] - s_cyc[0], s_code[i], exp_off[i]);
                end
            end
    endtask
`endif

    initial begin
        test_reset();
        test_key5();
        test_codes();
        test_bounce();
        test_multi();
        test_reset_held();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
